// File: rtl/ascii_pkg.sv
// Shared types and character constants for the ASCII record/playback buffer.
package ascii_pkg;

  typedef enum logic [1:0] {
    WRITE = 2'd0,
    READ  = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] CHAR_NUL = 8'h00;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_CR  = 8'h0D;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module bram_sdp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ascii_bram_writer.sv
// Records an ASCII message into BRAM until a terminator or full buffer, then plays
// it back one byte per re pulse with ROM-style dout/dout_valid/buf_end signalling.
module ascii_bram_writer
  import ascii_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  TERM_CHAR = CHAR_NUL
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [7:0]      din,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic            re,
  output logic [7:0]      dout,
  output logic            dout_valid,
  output logic            full,
  output logic            buf_end,
  output logic [ADDR_W:0] count
);

  localparam logic [ADDR_W-1:0] PtrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CntOne = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_dout_valid, r_full, r_buf_end;
  // Masks the un-reset BRAM output register until a real fetch has happened.
  logic              r_have_data;
  logic              w_wr_fire, w_rd_fire, w_wr_last, w_rd_last;
  logic [7:0]        w_rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WRITE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wr_fire    = 1'b0;
    w_rd_fire    = 1'b0;
    w_wr_last    = (r_wr_ptr == {ADDR_W{1'b1}});
    w_rd_last    = ({1'b0, r_rd_ptr} == (r_count - CntOne));
    if (clr) begin
      w_state_next = WRITE;
    end else begin
      unique case (r_state)
        WRITE: begin
          if (din_valid) begin
            w_wr_fire = 1'b1;
            if (din == TERM_CHAR || w_wr_last) w_state_next = READ;
          end
        end
        READ: begin
          if (re) begin
            w_rd_fire = 1'b1;
            if (w_rd_last) w_state_next = DONE;
          end
        end
        DONE:    w_state_next = DONE;
        default: w_state_next = WRITE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_full       <= 1'b0;
      r_buf_end    <= 1'b0;
      r_have_data  <= 1'b0;
    end else if (clr) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_full       <= 1'b0;
      r_buf_end    <= 1'b0;
      r_have_data  <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_fire;
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
        r_count  <= r_count + CntOne;
        if (w_wr_last) r_full <= 1'b1;
      end
      if (w_rd_fire) begin
        r_rd_ptr    <= r_rd_ptr + PtrOne;
        r_have_data <= 1'b1;
        if (w_rd_last) r_buf_end <= 1'b1;
      end
    end
  end

  bram_sdp #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_bram (
    .i_clk   (clk),
    .i_we    (w_wr_fire),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_re    (w_rd_fire),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign din_ready  = (r_state == WRITE);
  assign dout       = r_have_data ? w_rd_data : 8'h00;
  assign dout_valid = r_dout_valid;
  assign full       = r_full;
  assign buf_end    = r_buf_end;
  assign count      = r_count;

endmodule

// File: tb/tb_ascii_bram_writer.sv
// Directed bench for ascii_bram_writer: default-depth instance plus a 16-byte instance.
module tb_ascii_bram_writer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        clr, din_valid, re;
  logic [7:0]  din;
  logic        din_ready, dout_valid, full, buf_end;
  logic [7:0]  dout;
  logic [10:0] count;

  logic        clr4, din_valid4, re4;
  logic [7:0]  din4;
  logic        din_ready4, dout_valid4, full4, buf_end4;
  logic [7:0]  dout4;
  logic [4:0]  count4;

  int n_checks = 0;
  int n_errors = 0;

  ascii_bram_writer u_dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .re         (re),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .buf_end    (buf_end),
    .count      (count)
  );

  ascii_bram_writer #(
    .ADDR_W (4)
  ) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr4),
    .din        (din4),
    .din_valid  (din_valid4),
    .din_ready  (din_ready4),
    .re         (re4),
    .dout       (dout4),
    .dout_valid (dout_valid4),
    .full       (full4),
    .buf_end    (buf_end4),
    .count      (count4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    din       = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if (din_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_din_ready: got %b expected 1", din_ready);
    end
    n_checks++;
    if (dout !== 8'h00) begin
      n_errors++; $display("FAIL reset_dout: got %h expected 00", dout);
    end
    n_checks++;
    if (dout_valid !== 1'b0 || full !== 1'b0 || buf_end !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got valid=%b full=%b end=%b expected 0 0 0",
               dout_valid, full, buf_end);
    end
    n_checks++;
    if (count !== 11'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [7:0] msg [4] = '{8'h48, 8'h69, 8'h21, 8'h00};
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (din_ready !== 1'b1) begin
        n_errors++; $display("FAIL basic_ready_%0d: got %b expected 1", i, din_ready);
      end
      write_byte(msg[i]);
    end
    n_checks++;
    if (din_ready !== 1'b0 || count !== 11'd4) begin
      n_errors++;
      $display("FAIL basic_after_write: got ready=%b count=%0d expected 0 4", din_ready, count);
    end
    for (int i = 0; i < 4; i++) begin
      re = 1'b1;
      tick();
      re = 1'b0;
      n_checks++;
      if (dout_valid !== 1'b1 || dout !== msg[i] || buf_end !== (i == 3)) begin
        n_errors++;
        $display("FAIL basic_read_%0d: got valid=%b dout=%h end=%b expected 1 %h %b",
                 i, dout_valid, dout, buf_end, msg[i], (i == 3));
      end
      tick();
      n_checks++;
      if (dout_valid !== 1'b0 || dout !== msg[i]) begin
        n_errors++;
        $display("FAIL basic_hold_%0d: got valid=%b dout=%h expected 0 %h",
                 i, dout_valid, dout, msg[i]);
      end
    end
  endtask

  task automatic test_gapped_stream;
    logic [7:0] msg [4] = '{8'h61, 8'h62, 8'h63, 8'h00};
    pulse_clr();
    n_checks++;
    if (count !== 11'd0 || buf_end !== 1'b0 || din_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL gap_clr: got count=%0d end=%b ready=%b expected 0 0 1",
               count, buf_end, din_ready);
    end
    for (int i = 0; i < 4; i++) begin
      write_byte(msg[i]);
      tick();
    end
    n_checks++;
    if (count !== 11'd4) begin
      n_errors++; $display("FAIL gap_count: got %0d expected 4", count);
    end
    re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (dout_valid !== 1'b1 || dout !== msg[i] || buf_end !== (i == 3)) begin
        n_errors++;
        $display("FAIL gap_read_%0d: got valid=%b dout=%h end=%b expected 1 %h %b",
                 i, dout_valid, dout, buf_end, msg[i], (i == 3));
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (dout_valid !== 1'b0 || dout !== 8'h00 || buf_end !== 1'b1) begin
        n_errors++;
        $display("FAIL gap_done_%0d: got valid=%b dout=%h end=%b expected 0 00 1",
                 i, dout_valid, dout, buf_end);
      end
    end
    re = 1'b0;
  endtask

  task automatic test_full;
    logic [7:0] e;
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din4       = 8'h41 + 8'(i);
      din_valid4 = 1'b1;
      tick();
      if (i == 14) begin
        n_checks++;
        if (full4 !== 1'b0 || din_ready4 !== 1'b1) begin
          n_errors++;
          $display("FAIL full_early: got full=%b ready=%b expected 0 1", full4, din_ready4);
        end
      end
    end
    n_checks++;
    if (full4 !== 1'b1 || din_ready4 !== 1'b0 || count4 !== 5'd16) begin
      n_errors++;
      $display("FAIL full_set: got full=%b ready=%b count=%0d expected 1 0 16",
               full4, din_ready4, count4);
    end
    din4 = 8'h51;
    tick();
    din_valid4 = 1'b0;
    n_checks++;
    if (count4 !== 5'd16) begin
      n_errors++; $display("FAIL full_17th: got count=%0d expected 16", count4);
    end
    re4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      e = 8'h41 + 8'(i);
      n_checks++;
      if (dout_valid4 !== 1'b1 || dout4 !== e || buf_end4 !== (i == 15)) begin
        n_errors++;
        $display("FAIL full_read_%0d: got valid=%b dout=%h end=%b expected 1 %h %b",
                 i, dout_valid4, dout4, buf_end4, e, (i == 15));
      end
    end
    tick();
    re4 = 1'b0;
    n_checks++;
    if (dout_valid4 !== 1'b0 || dout4 !== 8'h50 || full4 !== 1'b1) begin
      n_errors++;
      $display("FAIL full_done: got valid=%b dout=%h full=%b expected 0 50 1",
               dout_valid4, dout4, full4);
    end
  endtask

  task automatic test_re_during_write;
    logic [7:0] msg [3] = '{8'h58, 8'h59, 8'h00};
    pulse_clr();
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      write_byte(msg[i]);
      if (i == 2) re = 1'b0;
      n_checks++;
      if (dout_valid !== 1'b0) begin
        n_errors++; $display("FAIL rew_valid_%0d: got %b expected 0", i, dout_valid);
      end
    end
    re = 1'b1;
    tick();
    re = 1'b0;
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h58) begin
      n_errors++;
      $display("FAIL rew_first: got valid=%b dout=%h expected 1 58", dout_valid, dout);
    end
  endtask

  task automatic test_clr;
    logic [7:0] ok [3] = '{8'h4F, 8'h4B, 8'h00};
    pulse_clr();
    write_byte(8'h51);
    n_checks++;
    if (count !== 11'd1) begin
      n_errors++; $display("FAIL clr_pre: got count=%0d expected 1", count);
    end
    din       = 8'h5A;
    din_valid = 1'b1;
    clr       = 1'b1;
    tick();
    clr       = 1'b0;
    din_valid = 1'b0;
    n_checks++;
    if (count !== 11'd0 || din_ready !== 1'b1 || full !== 1'b0 || buf_end !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_write: got count=%0d ready=%b full=%b end=%b expected 0 1 0 0",
               count, din_ready, full, buf_end);
    end
    for (int i = 0; i < 3; i++) write_byte(ok[i]);
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dout_valid !== 1'b1 || dout !== ok[i] || buf_end !== (i == 2)) begin
        n_errors++;
        $display("FAIL clr_ok_%0d: got valid=%b dout=%h end=%b expected 1 %h %b",
                 i, dout_valid, dout, buf_end, ok[i], (i == 2));
      end
    end
    re = 1'b0;
    pulse_clr();
    write_byte(8'h41);
    write_byte(8'h42);
    write_byte(8'h00);
    re = 1'b1;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    re  = 1'b0;
    n_checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h00 || buf_end !== 1'b0 || count !== 11'd0 ||
        din_ready !== 1'b1 || full !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_read: got valid=%b dout=%h end=%b count=%0d ready=%b full=%b",
               dout_valid, dout, buf_end, count, din_ready, full);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] ok [3] = '{8'h4F, 8'h4B, 8'h00};
    pulse_clr();
    write_byte(8'h4D);
    write_byte(8'h4E);
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (count !== 11'd0 || din_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL arst_write: got count=%0d ready=%b expected 0 1", count, din_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    write_byte(8'h50);
    write_byte(8'h00);
    re = 1'b1;
    tick();
    re = 1'b0;
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h50) begin
      n_errors++;
      $display("FAIL arst_pre: got valid=%b dout=%h expected 1 50", dout_valid, dout);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h00 || count !== 11'd0 || din_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL arst_read: got valid=%b dout=%h count=%0d ready=%b expected 0 00 0 1",
               dout_valid, dout, count, din_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) write_byte(ok[i]);
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dout_valid !== 1'b1 || dout !== ok[i] || buf_end !== (i == 2)) begin
        n_errors++;
        $display("FAIL arst_ok_%0d: got valid=%b dout=%h end=%b expected 1 %h %b",
                 i, dout_valid, dout, buf_end, ok[i], (i == 2));
      end
    end
    re = 1'b0;
  endtask

  initial begin
    clr = 1'b0; din = 8'h00; din_valid = 1'b0; re = 1'b0;
    clr4 = 1'b0; din4 = 8'h00; din_valid4 = 1'b0; re4 = 1'b0;
    test_reset();
    test_basic();
    test_gapped_stream();
    test_full();
    test_re_during_write();
    test_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ascii_bram_writer.md
Name: ascii_bram_writer

Overview:
Record-then-playback ASCII buffer; the write-side counterpart to the team's read-only ASCII BRAM ROM. Upstream logic (e.g. UART receiver) streams ASCII bytes in with a valid/ready handshake until a terminator character or a full buffer, then the stored message is read back byte-by-byte with the same re/dout/end-flag style as the ROM. Sits between the UART RX path and any consumer that expects ROM-style message playback.

Parameters:
ADDR_W, 10, BRAM address width; DEPTH = 2**ADDR_W bytes
TERM_CHAR, 8'h00, terminator byte; stored, then ends the write phase

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
clr  input  1  synchronous restart: return to write phase, empty buffer
din  input  8  ASCII byte to store
din_valid  input  1  din is valid this cycle
din_ready  output  1  writer accepts din this cycle
re  input  1  read-enable pulse: fetch next stored byte
dout  output  8  byte read back (registered)
dout_valid  output  1  one-cycle strobe: dout updated this cycle
full  output  1  buffer filled to DEPTH bytes
buf_end  output  1  last stored byte has been delivered on dout
count  output  ADDR_W+1  number of bytes stored in the current message

Behaviour:
- Reset (rst=0, async): state=WRITE, wr_ptr=0, rd_ptr=0, count=0, din_ready=1, dout=8'h00, dout_valid=0, full=0, buf_end=0. BRAM contents not cleared.
- FSM states: WRITE, READ, DONE.
- WRITE: din_ready=1. Transfer occurs when din_valid & din_ready: mem[wr_ptr]<=din, wr_ptr++, count++.
  - Accepted din==TERM_CHAR: byte is stored and counted, next state READ.
  - Accepted byte is the DEPTH-th: full=1, next state READ; no wrap-around.
  - re in WRITE: ignored; dout_valid stays 0.
- READ: din_ready=0 (combinational from state; 0 in the cycle after the final write). din_valid ignored.
  - re=1: BRAM read of mem[rd_ptr], rd_ptr++. Latency 1: dout/dout_valid update on the next edge.
  - Fetch of index count-1: buf_end=1 in the same cycle dout_valid presents that byte; next state DONE.
  - re held high: one byte per cycle, back-to-back.
- DONE: re ignored, dout holds the last byte, dout_valid=0, buf_end=1 and full keep their values until clr or reset.
- clr (synchronous, any state): same values as reset. It has priority over din_valid and re in the same cycle; the byte offered that cycle is not accepted.
- Reset mid-write or mid-read: the message is discarded (count=0). A pending dout_valid is cancelled.
- Width rules: wr_ptr/rd_ptr are ADDR_W bits. count is ADDR_W+1 bits so it can represent DEPTH.
- READ is only entered after at least one write, so count>=1 there. There is no empty-read case.

Decomposition:
- Package ascii_pkg: state enum (WRITE, READ, DONE); character constants CHAR_NUL=8'h00, CHAR_LF=8'h0A, CHAR_CR=8'h0D. TERM_CHAR defaults to CHAR_NUL.
- Sub-module bram_sdp: simple dual-port RAM, one write port and one registered read port, parameterised by ADDR_W and data width 8, coded for BRAM inference. No reset on the memory array.
- FSM, pointers and flags live in ascii_bram_writer.

Test Plan:
- Write "Hi!"+8'h00 (4 bytes), no gaps -> din_ready drops after byte 4, count=4. Four re pulses -> dout 0x48, 0x69, 0x21, 0x00 each 1 cycle after re; buf_end=1 with 0x00.
- Gapped din_valid and re held high continuously in READ -> same data, back-to-back dout_valid, buf_end on the last byte; further re -> dout_valid stays 0, dout holds.
- ADDR_W=4: write 16 bytes 0x41..0x50 with no terminator -> full=1 after the 16th, din_ready=0, 17th byte not stored. Readback gives 0x41..0x50 and buf_end on 0x50.
- re asserted during WRITE -> no dout_valid, rd_ptr unchanged; later readback starts at byte 0.
- clr in the same cycle as din_valid (and separately mid-READ) -> byte not accepted; count=0, din_ready=1, buf_end=0, full=0; a new message "OK"+0x00 reads back correctly.
- rst pulled low mid-write, asynchronously between clock edges -> all outputs take reset values immediately. After release, a fresh write/readback works.
